// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op codes, data widths, arbiter FSM states and request/result bundles.
// Imported by the arbiter, its interface and the round-robin picker.
package alu_arbiter_pkg;

   localparam int OP_W    = 6;
   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;
   localparam int CNT_W   = 3;

   localparam logic [OP_W-1:0] ALU_OP_ROTR = 6'h06;
   localparam logic [OP_W-1:0] ALU_OP_ADD  = 6'h20;
   localparam logic [OP_W-1:0] ALU_OP_ADDU = 6'h21;
   localparam logic [OP_W-1:0] ALU_OP_SUB  = 6'h22;
   localparam logic [OP_W-1:0] ALU_OP_SUBU = 6'h23;
   localparam logic [OP_W-1:0] ALU_OP_AND  = 6'h24;
   localparam logic [OP_W-1:0] ALU_OP_OR   = 6'h25;
   localparam logic [OP_W-1:0] ALU_OP_XOR  = 6'h26;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_EXEC,
      ARB_RESP
   } arb_state_t;

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
      logic [SHAMT_W-1:0] shamt;
   } alu_req_t;

   typedef struct packed {
      logic [DATA_W-1:0] out;
      logic              zero;
      logic              great;
      logic              overflow;
   } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals of the shared-ALU arbiter.
// slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arbiter_if
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int ID_W = 1
);

   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [OP_W*NREQ-1:0]    req_op;
   logic [DATA_W*NREQ-1:0]  req_a;
   logic [DATA_W*NREQ-1:0]  req_b;
   logic [SHAMT_W*NREQ-1:0] req_shamt;

   logic [OP_W-1:0]    alu_op;
   logic [DATA_W-1:0]  alu_a;
   logic [DATA_W-1:0]  alu_b;
   logic [SHAMT_W-1:0] alu_shamt;
   logic [DATA_W-1:0]  alu_out;
   logic               alu_zero;
   logic               alu_great;
   logic               alu_overflow;

   logic               rsp_valid;
   logic               rsp_ready;
   logic [ID_W-1:0]    rsp_id;
   logic [DATA_W-1:0]  rsp_out;
   logic               rsp_zero;
   logic               rsp_great;
   logic               rsp_overflow;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_shamt,
      input  alu_out, alu_zero, alu_great, alu_overflow,
      input  rsp_ready,
      output req_ready,
      output alu_op, alu_a, alu_b, alu_shamt,
      output rsp_valid, rsp_id, rsp_out,
      output rsp_zero, rsp_great, rsp_overflow
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_shamt,
      output alu_out, alu_zero, alu_great, alu_overflow,
      output rsp_ready,
      input  req_ready,
      input  alu_op, alu_a, alu_b, alu_shamt,
      input  rsp_valid, rsp_id, rsp_out,
      input  rsp_zero, rsp_great, rsp_overflow
   );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational picker: first set request searching upward from ptr, wrapping.
// With ptr tied to 0 it degenerates to fixed lowest-index priority.
module rr_pick #(
   parameter int NREQ = 2,
   parameter int ID_W = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] id,
   output logic            any
);

   always_comb begin
      grant = '0;
      id    = '0;
      any   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[(int'(ptr) + i) % NREQ]) begin
            any = 1'b1;
            grant[(int'(ptr) + i) % NREQ] = 1'b1;
            id = ID_W'((int'(ptr) + i) % NREQ);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: accept, wait ALU_LAT cycles, return result.
// Define ALU_ARB_RR_EN for round-robin; otherwise fixed lowest-index priority.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int ID_W    = 1,
   parameter int ALU_LAT = 1
) (
   input logic        clk,
   input logic        rst_n,
   alu_arbiter_if.slave bus
);

   arb_state_t       state_q;
   arb_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [ID_W-1:0]  id_q;
   alu_req_t         iss_q;
   alu_req_t         sel;
   alu_rsp_t         rsp_q;
   logic             accept;
   logic             capture;

   logic [ID_W-1:0]  ptr;
   logic [NREQ-1:0]  grant;
   logic [ID_W-1:0]  win;
   logic             any;

`ifdef ALU_ARB_RR_EN
   logic [ID_W-1:0] ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_pick (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (grant),
      .id    (win),
      .any   (any)
   );

   always_comb begin
      sel.op    = bus.req_op[int'(win)*OP_W +: OP_W];
      sel.a     = bus.req_a[int'(win)*DATA_W +: DATA_W];
      sel.b     = bus.req_b[int'(win)*DATA_W +: DATA_W];
      sel.shamt = bus.req_shamt[int'(win)*SHAMT_W +: SHAMT_W];
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (any) begin
               accept  = 1'b1;
               state_d = ARB_EXEC;
            end
         end
         ARB_EXEC: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         cnt_q   <= '0;
         id_q    <= '0;
         iss_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            iss_q <= sel;
            id_q  <= win;
            cnt_q <= CNT_W'(ALU_LAT - 1);
         end else if (state_q == ARB_EXEC && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (capture) begin
            rsp_q.out      <= bus.alu_out;
            rsp_q.zero     <= bus.alu_zero;
            rsp_q.great    <= bus.alu_great;
            rsp_q.overflow <= bus.alu_overflow;
         end
      end
   end

   // rst_n gates the strobe so an asserted reset drops it at once
   assign bus.req_ready = (rst_n && state_q == ARB_IDLE) ? grant : '0;

   assign bus.alu_op    = iss_q.op;
   assign bus.alu_a     = iss_q.a;
   assign bus.alu_b     = iss_q.b;
   assign bus.alu_shamt = iss_q.shamt;

   assign bus.rsp_valid    = (state_q == ARB_RESP);
   assign bus.rsp_id       = id_q;
   assign bus.rsp_out      = rsp_q.out;
   assign bus.rsp_zero     = rsp_q.zero;
   assign bus.rsp_great    = rsp_q.great;
   assign bus.rsp_overflow = rsp_q.overflow;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU, ALU_LAT=1, two requesters.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

`ifdef ALU_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.NREQ(2), .ID_W(1)) bus ();

   alu_arbiter #(
      .NREQ    (2),
      .ID_W    (1),
      .ALU_LAT (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] res;
   logic [63:0] rot;
   logic        ovf;

   // behavioural ALU: combinational from the arbiter's issue outputs
   always_comb begin
      res = '0;
      ovf = 1'b0;
      rot = {bus.alu_b, bus.alu_b} >> bus.alu_shamt;
      case (bus.alu_op)
         ALU_OP_ADD: begin
            res = bus.alu_a + bus.alu_b;
            ovf = (bus.alu_a[31] == bus.alu_b[31]) && (res[31] != bus.alu_a[31]);
         end
         ALU_OP_ADDU: res = bus.alu_a + bus.alu_b;
         ALU_OP_SUB: begin
            res = bus.alu_a - bus.alu_b;
            ovf = (bus.alu_a[31] != bus.alu_b[31]) && (res[31] != bus.alu_a[31]);
         end
         ALU_OP_SUBU: res = bus.alu_a - bus.alu_b;
         ALU_OP_AND:  res = bus.alu_a & bus.alu_b;
         ALU_OP_OR:   res = bus.alu_a | bus.alu_b;
         ALU_OP_XOR:  res = bus.alu_a ^ bus.alu_b;
         ALU_OP_ROTR: res = rot[31:0];
         default:     res = '0;
      endcase
      bus.alu_out      = res;
      bus.alu_zero     = (res == '0);
      bus.alu_great    = $signed(bus.alu_a) > $signed(bus.alu_b);
      bus.alu_overflow = ovf;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [1:0] v, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
      bus.req_valid = v;
      bus.req_op    = {op, op};
      bus.req_a     = {a, a};
      bus.req_b     = {b, b};
      bus.req_shamt = {sh, sh};
   endtask

   // one full transaction, entered and left just after a falling edge in IDLE
   task automatic txn(input string tag, input bit hold, input logic [1:0] v,
                      input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh,
                      input int exp_id, input logic [31:0] exp_out,
                      input logic exp_ovf, input logic exp_zero);
      int n;
      logic [1:0] one = 2'b01;
      set_req(v, op, a, b, sh);
      bus.rsp_ready = 1'b1;
      #1;
      check({tag, "_ready"}, 32'(bus.req_ready), 32'(one << exp_id));
      @(negedge clk);
      if (!hold) bus.req_valid = '0;
      n = 1;
      while (!bus.rsp_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'd2);
      check({tag, "_id"}, 32'(bus.rsp_id), 32'(exp_id));
      check({tag, "_out"}, bus.rsp_out, exp_out);
      check({tag, "_ovf"}, 32'(bus.rsp_overflow), 32'(exp_ovf));
      check({tag, "_zero"}, 32'(bus.rsp_zero), 32'(exp_zero));
      check({tag, "_rdy_resp"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_req(2'b11, ALU_OP_ADD, 32'h1, 32'h2, 5'd0);
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_alu_op", 32'(bus.alu_op), 32'd0);
      check("rst_rsp_out", bus.rsp_out, 32'd0);
      rst_n = 1'b1;
      bus.req_valid = '0;
      @(negedge clk);

      txn("t1_addu", 1'b0, 2'b01, ALU_OP_ADDU, 32'h40034003, 32'h5AD39AD3,
          5'd0, 0, 32'h9AD6DAD6, 1'b0, 1'b0);
      txn("t2_add", 1'b0, 2'b10, ALU_OP_ADD, 32'h40034003, 32'h5AD39AD3,
          5'd0, 1, 32'h9AD6DAD6, 1'b1, 1'b0);
      txn("t3_sub", 1'b0, 2'b01, ALU_OP_SUB, 32'hC0034003, 32'h7FD39AD3,
          5'd0, 0, 32'h402FA530, 1'b1, 1'b0);
      txn("t3_subu", 1'b0, 2'b10, ALU_OP_SUBU, 32'hC0034003, 32'h7FD39AD3,
          5'd0, 1, 32'h402FA530, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         txn("t4_rotr", 1'b1, 2'b11, ALU_OP_ROTR, 32'h0, 32'h9AD39AD3,
             5'd4, RR ? (i % 2) : 0, 32'h39AD39AD, 1'b0, 1'b0);
      end

      set_req(2'b11, ALU_OP_ADDU, 32'h40034003, 32'h5AD39AD3, 5'd0);
      bus.rsp_ready = 1'b0;
      #1;
      check("t5_ready", 32'(bus.req_ready), 32'd1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("t5_valid", 32'(bus.rsp_valid), 32'd1);
         check("t5_out", bus.rsp_out, 32'h9AD6DAD6);
         check("t5_id", 32'(bus.rsp_id), 32'd0);
         check("t5_ready_hold", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check("t5_next_ready", 32'(bus.req_ready), RR ? 32'd2 : 32'd1);

      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("t6_ready", 32'(bus.req_ready), 32'd0);
      check("t6_alu_a", bus.alu_a, 32'd0);
      @(negedge clk);
      bus.req_valid = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end

      txn("t7_zero", 1'b0, 2'b10, ALU_OP_SUBU, 32'h12345678, 32'h12345678,
          5'd0, 1, 32'h0, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
